dwc_read_checker: RTL and testbench

- Read-side controller placed directly downstream of the duplicated-with-comparison memory. It consumes the memory's read data and mismatch flag.
- Accepts client read requests over a valid/ready handshake and drives the memory read address.
- On a mismatch it re-reads the same word up to MAX_RETRY times, then returns the data with a fault tag.
- Keeps a saturating mismatch counter and a sticky fault flag for the status/health logic.

---
 rtl/dwc_read_checker.sv | 128 ++++++++++++
 tb/tb_dwc_read_checker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dwc_read_checker.sv
// Read controller behind a duplicated-with-comparison memory: re-reads mismatching words up to MAX_RETRY times.
// Latency READ_LATENCY*(retries+1) cycles to rsp_valid; one request in flight, response held until rsp_ready.
module dwc_read_checker #(
  parameter int bits         = 8,
  parameter int words        = 4,
  parameter int address      = $clog2(words),
  parameter int READ_LATENCY = 1,
  parameter int MAX_RETRY    = 2,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [address-1:0]   req_addr,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [bits-1:0]      rsp_data,
  output logic                 rsp_fault,
  output logic [address-1:0]   mem_r_addr,
  input  logic [bits-1:0]      mem_r_data,
  input  logic                 mem_error,
  input  logic                 clear_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 fault_sticky
);

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic               init_done;
  logic [LAT_W-1:0]   lat;
  logic [RTY_W-1:0]   retry;
  logic [address-1:0] addr_q;
  logic               accept, sample, do_retry, done_ok, done_fault;
  logic               err_inc;

  // init_done keeps req_ready low while reset is held, even though state is IDLE
  assign req_ready  = init_done && (state == IDLE);
  assign rsp_valid  = (state == RESP);
  assign mem_r_addr = addr_q;
  assign err_inc    = sample && mem_error;

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    sample     = 1'b0;
    do_retry   = 1'b0;
    done_ok    = 1'b0;
    done_fault = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (lat == LAT_W'(READ_LATENCY - 1)) begin
          sample = 1'b1;
          if (!mem_error) begin
            done_ok   = 1'b1;
            state_nxt = RESP;
          end else if (int'(retry) < MAX_RETRY) begin
            do_retry = 1'b1;
          end else begin
            done_fault = 1'b1;
            state_nxt  = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      lat       <= '0;
      retry     <= '0;
      rsp_data  <= '0;
      rsp_fault <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
        lat    <= '0;
        retry  <= '0;
      end else if (state == WAIT) begin
        lat <= sample ? '0 : lat + LAT_W'(1);
        if (do_retry) retry <= retry + RTY_W'(1);
      end
      if (done_ok || done_fault) begin
        rsp_data  <= mem_r_data;
        rsp_fault <= done_fault;
      end
    end
  end

  // A clear in the same cycle as a new mismatch keeps that mismatch counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count    <= '0;
      fault_sticky <= 1'b0;
    end else begin
      if (clear_count) err_count <= err_inc ? CNT_WIDTH'(1) : '0;
      else if (err_inc && (err_count != '1)) err_count <= err_count + CNT_WIDTH'(1);
      if (done_fault) fault_sticky <= 1'b1;
      else if (clear_count) fault_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dwc_read_checker.sv
// Directed bench for dwc_read_checker: scoreboard queue of expected responses, monitor compares on handshake.
module tb_dwc_read_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready;
  logic [1:0] req_addr;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_fault;
  logic [1:0] mem_r_addr;
  logic [7:0] mem_r_data;
  logic       mem_error;
  logic       clear_count;
  logic [1:0] err_count;
  logic       fault_sticky;

  logic [7:0] mem [4];
  logic [8:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;
  assign mem_r_data = mem[mem_r_addr];

  dwc_read_checker #(
    .bits(8), .words(4), .READ_LATENCY(1), .MAX_RETRY(2), .CNT_WIDTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data), .mem_error(mem_error),
    .clear_count(clear_count), .err_count(err_count), .fault_sticky(fault_sticky)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a response is consumed on the edge following a negedge where valid&ready hold
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("rsp_data", {24'd0, rsp_data}, {24'd0, e[7:0]});
        check("rsp_fault", {31'd0, rsp_fault}, {31'd0, e[8]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
  endtask

  // nerr: number of leading samples that see a mismatch; clr_at: sample index with clear_count high
  task automatic issue(input logic [1:0] a, input logic [7:0] ed, input logic ef,
                       input int nerr, input int clr_at, input int exp_lat);
    int n;
    int cyc;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    exp_q.push_back({ef, ed});
    tick();
    req_valid = 1'b0;
    req_addr  = ~a;
    check("mem_r_addr", {30'd0, mem_r_addr}, {30'd0, a});
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      mem_error   = (cyc < nerr);
      clear_count = (cyc == clr_at);
      tick();
      cyc++;
    end
    mem_error   = 1'b0;
    clear_count = 1'b0;
    check("rsp_latency", cyc, exp_lat);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic stable;
    mem[0] = 8'h5A; mem[1] = 8'h3C; mem[2] = 8'hA5; mem[3] = 8'hC3;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = 2'd0; rsp_ready = 1'b1;
    mem_error = 1'b0; clear_count = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_mem_r_addr", {30'd0, mem_r_addr}, 32'd0);
    check("rst_err_count", {30'd0, err_count}, 32'd0);
    check("rst_fault_sticky", {31'd0, fault_sticky}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Mismatch flag while idle is not a sample
    mem_error = 1'b1;
    repeat (3) tick();
    mem_error = 1'b0;
    check("idle_err_ignored", {30'd0, err_count}, 32'd0);

    // Clean read
    issue(2'd2, 8'hA5, 1'b0, 0, -1, 1);
    wait_idle();
    check("clean_err_count", {30'd0, err_count}, 32'd0);

    // Transient mismatch: one re-read
    issue(2'd1, 8'h3C, 1'b0, 1, -1, 2);
    wait_idle();
    check("transient_err_count", {30'd0, err_count}, 32'd1);
    check("transient_sticky", {31'd0, fault_sticky}, 32'd0);

    // Backpressure, with mismatch noise while holding the response
    rsp_ready = 1'b0;
    issue(2'd0, 8'h5A, 1'b0, 0, -1, 1);
    stable = 1'b1;
    mem_error = 1'b1;
    repeat (5) begin
      tick();
      if (!(rsp_valid && rsp_data == 8'h5A && !rsp_fault && !req_ready)) stable = 1'b0;
    end
    mem_error = 1'b0;
    check("bp_stable", {31'd0, stable}, 32'd1);
    check("bp_err_ignored", {30'd0, err_count}, 32'd1);
    rsp_ready = 1'b1;
    check("bp_no_ready_same_cycle", {31'd0, req_ready}, 32'd0);
    tick();
    check("bp_ready_after_hs", {31'd0, req_ready}, 32'd1);
    check("bp_valid_dropped", {31'd0, rsp_valid}, 32'd0);

    // Persistent mismatch: three samples then fault
    pulse_clear();
    check("clear_err_count", {30'd0, err_count}, 32'd0);
    issue(2'd3, 8'hC3, 1'b1, 3, -1, 3);
    wait_idle();
    check("persist_err_count", {30'd0, err_count}, 32'd3);
    check("persist_sticky", {31'd0, fault_sticky}, 32'd1);

    // Saturation at 3 for a 2-bit counter
    issue(2'd3, 8'hC3, 1'b1, 3, -1, 3);
    wait_idle();
    check("sat_err_count", {30'd0, err_count}, 32'd3);

    // Clear coincident with a mismatch sample keeps that one count; sticky clears
    issue(2'd1, 8'h3C, 1'b0, 1, 0, 2);
    wait_idle();
    check("clr_inc_err_count", {30'd0, err_count}, 32'd1);
    check("clr_inc_sticky", {31'd0, fault_sticky}, 32'd0);

    // Clear coincident with a fault set: sticky wins, count restarts at 1
    issue(2'd2, 8'hA5, 1'b1, 3, 2, 3);
    wait_idle();
    check("clr_fault_err_count", {30'd0, err_count}, 32'd1);
    check("clr_fault_sticky", {31'd0, fault_sticky}, 32'd1);

    // Clear alone
    pulse_clear();
    check("clear_alone_count", {30'd0, err_count}, 32'd0);
    check("clear_alone_sticky", {31'd0, fault_sticky}, 32'd0);

    // Reset during a retry abandons the transaction
    wait_idle();
    req_valid = 1'b1;
    req_addr  = 2'd3;
    tick();
    req_valid = 1'b0;
    mem_error = 1'b1;
    tick();
    check("mid_wait_err_count", {30'd0, err_count}, 32'd1);
    rst_n = 1'b0;
    #1;
    mem_error = 1'b0;
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_err_count", {30'd0, err_count}, 32'd0);
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("mid_rst_mem_r_addr", {30'd0, mem_r_addr}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("mid_rst_release_ready", {31'd0, req_ready}, 32'd1);
    issue(2'd2, 8'hA5, 1'b0, 0, -1, 1);
    wait_idle();

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
